spi_reg_responder: RTL and testbench

- SPI mode-0 responder (target) sitting behind the Tiny Tapeout user pins; the counterpart to the cocotb/bench initiator that drives ui_in and samples uo_out/uio_out.
- Decodes 16-bit frames into writes/reads of a small 8-bit register file, whose contents drive the design's outputs.
- All SPI pins are oversampled in the system clock domain; there is no logic clocked by sclk.

---
 rtl/spi_reg_responder.sv | 175 +++++++++++++++++
 tb/tb_spi_reg_responder.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_responder.sv
// SPI mode-0 register responder, fully oversampled in the clk domain.
// Define SPI_FRAME_COUNT_EN to add a read-only committed-write counter at address NUM_REGS.
module spi_reg_responder #(
  parameter int unsigned NUM_REGS = 4,
  parameter logic [7:0]  ID_VALUE = 8'hA5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic                    sclk,
  input  logic                    cs_n,
  input  logic                    mosi,
  output logic                    miso,
  output logic                    miso_oe,
  output logic [8*NUM_REGS-1:0]   regs_out,
  output logic                    wr_strobe
);

  typedef enum logic [1:0] {StIdle, StCmd, StData, StDone} state_e;

  localparam logic [6:0] NumRegsA = 7'(NUM_REGS);

  logic sclk_s1, sclk_s2, sclk_s3;
  logic cs_n_s1, cs_n_s2;
  logic mosi_s1, mosi_s2;
  logic sel, sel_q;
  logic rise, fall;

  state_e                     state_q, state_d;
  logic [3:0]                 cnt_q, cnt_d;
  logic [6:0]                 shift_q, shift_d;
  logic                       is_wr_q, is_wr_d;
  logic [6:0]                 addr_q, addr_d;
  logic [7:0]                 tx_q, tx_d;
  logic                       miso_q, miso_d;
  logic                       wr_q, wr_d;
  logic [NUM_REGS-1:0][7:0]   regs_q, regs_d;
  logic [6:0]                 cmd_addr;
  logic [7:0]                 rdata;
`ifdef SPI_FRAME_COUNT_EN
  logic [7:0]                 fcnt_q, fcnt_d;
`endif

  assign sel      = ~cs_n_s2 & ena;
  assign rise     = sclk_s2 & ~sclk_s3;
  assign fall     = ~sclk_s2 & sclk_s3;
  assign cmd_addr = {shift_q[5:0], mosi_s2};

  assign miso      = miso_q;
  assign miso_oe   = sel_q;
  assign wr_strobe = wr_q;
  assign regs_out  = regs_q;

  // Read data is sampled against the address completed by the 8th rise.
  always_comb begin
    rdata = ID_VALUE;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (cmd_addr == 7'(i)) rdata = regs_q[i];
    end
`ifdef SPI_FRAME_COUNT_EN
    if (cmd_addr == NumRegsA) rdata = fcnt_q;
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    is_wr_d = is_wr_q;
    addr_d  = addr_q;
    tx_d    = tx_q;
    miso_d  = miso_q;
    wr_d    = 1'b0;
    regs_d  = regs_q;
`ifdef SPI_FRAME_COUNT_EN
    fcnt_d  = fcnt_q;
`endif
    if (!sel) begin
      // Deselect aborts any frame before it can commit.
      state_d = StIdle;
      cnt_d   = 4'd0;
      miso_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          cnt_d  = 4'd0;
          miso_d = 1'b0;
          if (!sel_q) state_d = StCmd;
        end
        StCmd: begin
          if (rise) begin
            shift_d = {shift_q[5:0], mosi_s2};
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              is_wr_d = shift_q[6];
              addr_d  = cmd_addr;
              tx_d    = rdata;
              state_d = StData;
            end
          end
        end
        StData: begin
          if (rise) begin
            shift_d = {shift_q[5:0], mosi_s2};
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
              state_d = StDone;
              if (is_wr_q && addr_q < NumRegsA) begin
                wr_d = 1'b1;
                for (int i = 0; i < NUM_REGS; i++) begin
                  if (addr_q == 7'(i)) regs_d[i] = {shift_q[6:0], mosi_s2};
                end
`ifdef SPI_FRAME_COUNT_EN
                fcnt_d = fcnt_q + 8'd1;
`endif
              end
            end
          end else if (fall && !is_wr_q) begin
            miso_d = tx_q[7];
            tx_d   = {tx_q[6:0], 1'b0};
          end
        end
        StDone: ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_s3 <= 1'b0;
      cs_n_s1 <= 1'b1;
      cs_n_s2 <= 1'b1;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
      sel_q   <= 1'b0;
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      shift_q <= 7'd0;
      is_wr_q <= 1'b0;
      addr_q  <= 7'd0;
      tx_q    <= 8'd0;
      miso_q  <= 1'b0;
      wr_q    <= 1'b0;
      regs_q  <= '0;
`ifdef SPI_FRAME_COUNT_EN
      fcnt_q  <= 8'd0;
`endif
    end else begin
      sclk_s1 <= sclk;
      sclk_s2 <= sclk_s1;
      sclk_s3 <= sclk_s2;
      cs_n_s1 <= cs_n;
      cs_n_s2 <= cs_n_s1;
      mosi_s1 <= mosi;
      mosi_s2 <= mosi_s1;
      sel_q   <= sel;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      is_wr_q <= is_wr_d;
      addr_q  <= addr_d;
      tx_q    <= tx_d;
      miso_q  <= miso_d;
      wr_q    <= wr_d;
      regs_q  <= regs_d;
`ifdef SPI_FRAME_COUNT_EN
      fcnt_q  <= fcnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_spi_reg_responder.sv
// Scoreboard bench for spi_reg_responder: stimulus queues expected writes/reads,
// monitors pop them on wr_strobe pulses and on completed read frames.
module tb_spi_reg_responder;

  localparam int unsigned NR   = 4;
  localparam int          HALF = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b1;
  logic sclk = 1'b0;
  logic cs_n = 1'b1;
  logic mosi = 1'b0;
  logic miso, miso_oe, wr_strobe;
  logic [8*NR-1:0] regs_out;

  always #5 clk = ~clk;

  spi_reg_responder #(.NUM_REGS(NR), .ID_VALUE(8'hA5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .sclk      (sclk),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .miso      (miso),
    .miso_oe   (miso_oe),
    .regs_out  (regs_out),
    .wr_strobe (wr_strobe)
  );

  int n_checks = 0;
  int n_fail = 0;
  int n_strobe = 0;
  logic [8*NR-1:0] exp_regs = '0;
  logic [8*NR-1:0] wr_q[$];
  logic [7:0]      rd_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Write monitor: each strobe must match a queued write.
  always @(negedge clk) begin
    if (rst_n && wr_strobe === 1'b1) begin
      n_strobe++;
      if (wr_q.size() == 0) check("wr_strobe with no write pending", 32'(wr_strobe), 32'd0);
      else check("regs_out after write", regs_out, wr_q.pop_front());
    end
  end

  // Read monitor: capture the bus like an initiator, compare completed read frames.
  initial begin
    logic [15:0] mo_sh, mi_sh;
    int nbits;
    forever begin
      @(negedge cs_n);
      nbits = 0;
      mo_sh = '0;
      mi_sh = '0;
      while (cs_n == 1'b0) begin
        @(posedge sclk or posedge cs_n);
        if (!cs_n) begin
          mo_sh = {mo_sh[14:0], mosi};
          mi_sh = {mi_sh[14:0], miso};
          nbits++;
        end
      end
      if (nbits == 16 && !mo_sh[15] && ena && rst_n) begin
        if (rd_q.size() == 0) check("read with nothing expected", rd_q.size(), 32'd1);
        else check("miso read byte", 32'(mi_sh[7:0]), 32'(rd_q.pop_front()));
      end
    end
  end

  task automatic spi_xfer(input logic [15:0] f, input int nrises, input bit hold_cs);
    @(negedge clk);
    cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 15; i >= 16 - nrises; i--) begin
      mosi = f[i];
      if (i == 11) check("miso_oe during frame", 32'(miso_oe), 32'(ena));
      repeat (HALF) @(negedge clk);
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
    if (!hold_cs) begin
      repeat (HALF) @(negedge clk);
      cs_n = 1'b1;
      mosi = 1'b0;
      repeat (HALF + 4) @(negedge clk);
      check("miso_oe after deselect", 32'(miso_oe), 32'd0);
    end
  endtask

  task automatic spi_write(input logic [6:0] addr, input logic [7:0] data);
    if (addr < 7'(NR)) begin
      exp_regs[8*addr +: 8] = data;
      wr_q.push_back(exp_regs);
    end
    spi_xfer({1'b1, addr, data}, 16, 1'b0);
  endtask

  task automatic spi_read(input logic [6:0] addr, input logic [7:0] expd);
    rd_q.push_back(expd);
    spi_xfer({1'b0, addr, 8'h00}, 16, 1'b0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    repeat (4) @(negedge clk);
    check("reset regs_out", regs_out, 32'd0);
    check("reset miso", 32'(miso), 32'd0);
    check("reset miso_oe", 32'(miso_oe), 32'd0);
    check("reset wr_strobe", 32'(wr_strobe), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    spi_read(7'h02, 8'h00);
    check("regs_out after first read", regs_out, 32'h0000_0000);

    s0 = n_strobe;
    spi_write(7'h01, 8'h5A);
    check("one strobe for write 0x815A", n_strobe - s0, 32'd1);
    check("regs_out after 0x815A", regs_out, 32'h0000_5A00);
    spi_read(7'h01, 8'h5A);

    spi_read(7'h40, 8'hA5);
    s0 = n_strobe;
    spi_write(7'h40, 8'h33);
    check("no strobe for unmapped write", n_strobe - s0, 32'd0);
    check("regs_out after unmapped write", regs_out, 32'h0000_5A00);

    s0 = n_strobe;
    spi_xfer(16'h83FF, 12, 1'b0);
    check("no strobe for aborted frame", n_strobe - s0, 32'd0);
    check("reg3 after aborted frame", regs_out, 32'h0000_5A00);
    spi_write(7'h03, 8'hFF);
    check("reg3 after full frame", regs_out, 32'hFF00_5A00);

    ena = 1'b0;
    s0 = n_strobe;
    spi_xfer(16'h8011, 16, 1'b0);
    check("no strobe with ena low", n_strobe - s0, 32'd0);
    check("regs_out with ena low", regs_out, 32'hFF00_5A00);
    ena = 1'b1;

    spi_xfer(16'h8155, 10, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid-frame reset regs_out", regs_out, 32'd0);
    check("mid-frame reset miso", 32'(miso), 32'd0);
    check("mid-frame reset miso_oe", 32'(miso_oe), 32'd0);
    check("mid-frame reset wr_strobe", 32'(wr_strobe), 32'd0);
    exp_regs = '0;
    @(negedge clk);
    cs_n = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    spi_read(7'h01, 8'h00);

`ifdef SPI_FRAME_COUNT_EN
    for (int k = 0; k < 257; k++) spi_write(7'(k % 4), 8'(k));
    spi_read(7'(NR), 8'h01);
`else
    spi_read(7'(NR), 8'hA5);
`endif

    repeat (10) @(negedge clk);
    check("pending writes drained", wr_q.size(), 32'd0);
    check("pending reads drained", rd_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
